ft232r_tx_fc: RTL and testbench

FPGA-to-FT232R transmit path with hardware flow control: logic-side bytes are buffered in a small FIFO and serialized as 8N1 UART on rxd.
Transmission is gated by the FT232R's RTS# output, so the host side can throttle the FPGA.
It complements the existing receive-side handshaking adapter and shares its rsp_req/rsp_ack 4-phase logic interface, so either can drive the response path.

---
 rtl/ft232r_tx_fc.sv | 153 +++++++++++++++
 tb/tb_ft232r_tx_fc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ft232r_tx_fc.sv
// FT232R transmit path: 4-phase write handshake into a small FIFO, drained as
// 8N1 UART on rxd, throttled at frame boundaries by the FT232R's RTS# line.
`timescale 1ns/1ps
module ft232r_tx_fc #(
    parameter int P_CLK_FREQ_HZ = 125_000_000,
    parameter int P_BAUD_RATE   = 1_000_000,
    parameter int P_FIFO_AW     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 rxd,
    input  logic                 ft_rts_n,
    input  logic                 fc_en,
    input  logic                 rsp_req,
    input  logic [7:0]           rsp_data,
    output logic                 rsp_ack,
    output logic [P_FIFO_AW:0]   fifo_count,
    output logic                 busy
);
    localparam int N     = P_CLK_FREQ_HZ / P_BAUD_RATE;
    localparam int CW    = (N > 2) ? $clog2(N) : 1;
    localparam int DEPTH = 2 ** P_FIFO_AW;
    localparam logic [CW-1:0]      BIT_LAST = CW'(N - 1);
    localparam logic [P_FIFO_AW:0] FULL_CNT = (P_FIFO_AW + 1)'(DEPTH);

    localparam logic [0:0] H_IDLE  = 1'b0;
    localparam logic [0:0] H_ACK   = 1'b1;
    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_START = 2'd1;
    localparam logic [1:0] T_DATA  = 2'd2;
    localparam logic [1:0] T_STOP  = 2'd3;

    logic                 rts_meta, rts_sync, cts_ok;
    logic [0:0]           h_state;
    logic [1:0]           t_state;
    logic [CW-1:0]        bit_cnt;
    logic [2:0]           idx;
    logic [7:0]           sh;
    logic [7:0]           mem [DEPTH];
    logic [P_FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic                 full, empty, bit_last, push, pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {rts_sync, rts_meta} <= 2'b11;
        else     {rts_sync, rts_meta} <= {rts_meta, ft_rts_n};
    end

    assign cts_ok   = !fc_en | !rts_sync;
    assign full     = (fifo_count == FULL_CNT);
    assign empty    = (fifo_count == '0);
    assign bit_last = (bit_cnt == BIT_LAST);
    // Flow control is only consulted at frame boundaries, so a frame never truncates.
    assign pop  = !empty && cts_ok && ((t_state == T_IDLE) || ((t_state == T_STOP) && bit_last));
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push = (h_state == H_IDLE) && rsp_req && (!full || pop);
    assign busy = (t_state != T_IDLE) || (fifo_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_state <= H_IDLE;
            rsp_ack <= 1'b0;
        end else if (h_state == H_IDLE) begin
            if (push) begin
                rsp_ack <= 1'b1;
                h_state <= H_ACK;
            end
        end else if (!rsp_req) begin
            rsp_ack <= 1'b0;
            h_state <= H_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_state <= T_IDLE;
            bit_cnt <= '0;
            idx     <= '0;
            rxd     <= 1'b1;
        end else begin
            case (t_state)
                T_IDLE: begin
                    if (pop) begin
                        rxd     <= 1'b0;
                        bit_cnt <= '0;
                        t_state <= T_START;
                    end
                end
                T_START: begin
                    if (bit_last) begin
                        rxd     <= sh[0];
                        bit_cnt <= '0;
                        idx     <= '0;
                        t_state <= T_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                T_DATA: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (idx == 3'd7) begin
                            rxd     <= 1'b1;
                            t_state <= T_STOP;
                        end else begin
                            rxd <= sh[0];
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            rxd     <= 1'b0;
                            t_state <= T_START;
                        end else begin
                            t_state <= T_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage and shift register carry no reset; control above gates their use.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rsp_data;
        if (pop)
            sh <= mem[rd_ptr];
        else if (bit_last && ((t_state == T_START) || (t_state == T_DATA)))
            sh <= {1'b0, sh[7:1]};
    end
endmodule

// File: tb/tb_ft232r_tx_fc.sv
// Bench for ft232r_tx_fc: accepted bytes are queued as expectations, and a UART
// decoder watching rxd pops and compares every frame it sees.
`timescale 1ns/1ps
module tb_ft232r_tx_fc;
    localparam int N = 125;

    logic       clk = 1'b0;
    logic       rst, rxd, ft_rts_n, fc_en, rsp_req, rsp_ack, busy;
    logic [7:0] rsp_data;
    logic [4:0] fifo_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    ft232r_tx_fc dut (
        .clk(clk), .rst(rst), .rxd(rxd), .ft_rts_n(ft_rts_n), .fc_en(fc_en),
        .rsp_req(rsp_req), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
        .fifo_count(fifo_count), .busy(busy)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, req);
    endtask

    // UART decoder: samples each bit near its centre, abandons frames cut by reset.
    task automatic mon_wait(input int n, inout bit ab);
        repeat (n) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
        end
    endtask

    initial begin
        logic       prev, s0, s1;
        logic [7:0] got;
        bit         ab;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
            end else if (prev && !rxd) begin
                starts.push_back(cyc);
                ab = 1'b0;
                mon_wait(N / 2 - 1, ab);
                s0 = rxd;
                for (int i = 0; i < 8; i++) begin
                    mon_wait(N, ab);
                    got[i] = rxd;
                end
                mon_wait(N, ab);
                s1 = rxd;
                if (!ab) begin
                    chk("frame_start_bit", {31'd0, s0}, 32'd0);
                    chk("frame_stop_bit", {31'd0, s1}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL byte_unexpected: got %02h, required nothing queued", got);
                    end else begin
                        chk("byte_order", {24'd0, got}, {24'd0, exp_q.pop_front()});
                    end
                end
                prev = 1'b1;
            end else begin
                prev = rxd;
            end
        end
    end

    task automatic send(input logic [7:0] b, input int lim);
        int k;
        rsp_data = b;
        rsp_req  = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp_ack && k < lim);
        if (!rsp_ack) chk("send_ack_timeout", {31'd0, rsp_ack}, 32'd1);
        else exp_q.push_back(b);
        rsp_data = ~b;
        rsp_req  = 1'b0;
        k = 0;
        while (rsp_ack && k < lim) begin @(negedge clk); k++; end
        if (rsp_ack) chk("send_ack_release", {31'd0, rsp_ack}, 32'd0);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain(input string nm, input int lim);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < lim) begin @(negedge clk); k++; end
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
        chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_gaps(input string nm, input int first, input int cnt);
        int bad;
        bad = 0;
        chk({nm, "_frames"}, starts.size() - first, cnt);
        if (starts.size() - first >= cnt)
            for (int j = 1; j < cnt; j++)
                if (starts[first + j] - starts[first + j - 1] != 10 * N) bad++;
        chk({nm, "_back_to_back"}, bad, 0);
    endtask

    initial begin
        #760000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c0, s, k, ns0, ns1;
        bit         seen_low;
        logic [7:0] b;

        rst = 1'b1; ft_rts_n = 1'b1; fc_en = 1'b0; rsp_req = 1'b0; rsp_data = 8'h00;
        repeat (4) @(negedge clk);
        chk("reset_rxd", {31'd0, rxd}, 32'd1);
        chk("reset_ack", {31'd0, rsp_ack}, 32'd0);
        chk("reset_count", {27'd0, fifo_count}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte, flow control ignored.
        rsp_data = 8'hA5; rsp_req = 1'b1; exp_q.push_back(8'hA5);
        @(negedge clk);
        chk("t1_ack_rise", {31'd0, rsp_ack}, 32'd1);
        chk("t1_rxd_still_idle", {31'd0, rxd}, 32'd1);
        chk("t1_count_one", {27'd0, fifo_count}, 32'd1);
        @(negedge clk);
        chk("t1_start_bit", {31'd0, rxd}, 32'd0);
        chk("t1_count_popped", {27'd0, fifo_count}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        c0 = cyc;
        rsp_req = 1'b0;
        @(negedge clk);
        chk("t1_ack_clear", {31'd0, rsp_ack}, 32'd0);
        k = 0;
        while (busy && k < 3000) begin @(negedge clk); k++; end
        chk("t1_frame_len", cyc - c0, 10 * N);
        drain("t1", 200);

        // Burst of 20 with the transmitter stalled.
        fc_en = 1'b1; ft_rts_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) send(8'(i), 50);
        chk("burst_count_full", {27'd0, fifo_count}, 32'd16);
        ns0 = starts.size();
        rsp_data = 8'h10; rsp_req = 1'b1;
        repeat (20) @(negedge clk);
        chk("burst_17th_blocked", {31'd0, rsp_ack}, 32'd0);
        ft_rts_n = 1'b0;
        k = 0;
        while (!rsp_ack && k < 10) begin @(negedge clk); k++; end
        chk("burst_17th_latency", k, 3);
        chk("burst_pop_same_edge", {31'd0, rxd}, 32'd0);
        chk("burst_count_write_pop", {27'd0, fifo_count}, 32'd16);
        if (rsp_ack) exp_q.push_back(8'h10);
        rsp_data = 8'hEE; rsp_req = 1'b0;
        k = 0;
        while (rsp_ack && k < 10) begin @(negedge clk); k++; end
        for (int i = 17; i < 20; i++) send(8'(i), 3000);
        drain("burst", 30000);
        chk_gaps("burst", ns0, 20);

        // RTS# raised during bit 3, two bytes queued behind.
        ns0 = starts.size();
        send(8'h3C, 50);
        send(8'($urandom_range(0, 255)), 50);
        send(8'($urandom_range(0, 255)), 50);
        k = 0;
        while (starts.size() == ns0 && k < 100) begin @(negedge clk); k++; end
        s = (starts.size() > ns0) ? starts[ns0] : cyc;
        wait_until(s + 4 * N + 40);
        ft_rts_n = 1'b1;
        wait_until(s + 10 * N - 2);
        seen_low = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (!rxd) seen_low = 1'b1;
        end
        chk("fc_held_idle", {31'd0, seen_low}, 32'd0);
        chk("fc_count_held", {27'd0, fifo_count}, 32'd2);
        chk("fc_one_frame", starts.size() - ns0, 1);
        ft_rts_n = 1'b0;
        k = 0;
        while (rxd && k < 20) begin @(negedge clk); k++; end
        chk("fc_resume_latency", {31'd0, (k >= 3 && k <= 4)}, 32'd1);
        drain("fc", 5000);

        // Flow control disabled: RTS# high must not stall.
        ft_rts_n = 1'b1; fc_en = 1'b0;
        ns0 = starts.size();
        for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 50);
        drain("nofc", 5000);
        chk_gaps("nofc", ns0, 3);

        // Async reset in the middle of a data bit with five bytes still queued.
        fc_en = 1'b1; ft_rts_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)), 50);
        ns0 = starts.size();
        ft_rts_n = 1'b0;
        k = 0;
        while (starts.size() == ns0 && k < 100) begin @(negedge clk); k++; end
        s = (starts.size() > ns0) ? starts[ns0] : cyc;
        wait_until(s + 3 * N + 50);
        chk("rst_pre_count", {27'd0, fifo_count}, 32'd5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_rxd", {31'd0, rxd}, 32'd1);
        chk("rst_async_ack", {31'd0, rsp_ack}, 32'd0);
        chk("rst_async_count", {27'd0, fifo_count}, 32'd0);
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ns1 = starts.size();
        repeat (2000) @(negedge clk);
        chk("rst_no_residual", starts.size() - ns1, 0);
        chk("rst_after_busy", {31'd0, busy}, 32'd0);

        // Random traffic with random flow-control settings.
        for (int i = 0; i < 10; i++) begin
            fc_en    = 1'($urandom_range(0, 1));
            ft_rts_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                b = 8'($urandom_range(0, 255));
                send(b, 5000);
            end
            repeat ($urandom_range(0, 900)) @(negedge clk);
        end
        ft_rts_n = 1'b0;
        drain("random", 20000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
